// File: rtl/fp_series_accum.sv
// Sequencer that folds a stream of IEEE-754 terms through an external addsub unit,
// one addition at a time (op1 = running sum, op2 = new term).
module fp_series_accum #(
  parameter int CNT_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  input  logic             term_valid,
  input  logic [31:0]      term_data,
  output logic             term_ready,
  output logic [31:0]      op1,
  output logic [31:0]      op2,
  input  logic [31:0]      add_result,
  input  logic             add_done,
  input  logic             add_overflow,
  output logic [31:0]      sum,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_TERM, S_ISSUE, S_WAIT_ADD, S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [31:0]      op1_q, op1_d, op2_q, op2_d, sum_q, sum_d;
  logic             ovf_q, ovf_d, tout_q, tout_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      tmr_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tmr_q   <= tmr_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      tout_q  <= tout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    tmr_d   = tmr_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    tout_d  = tout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = num_terms;
          sum_d   = 32'h0;
          ovf_d   = 1'b0;
          tout_d  = 1'b0;
          state_d = (num_terms == '0) ? S_FINISH : S_WAIT_TERM;
        end
      end
      S_WAIT_TERM: begin
        if (term_valid) begin
          op1_d   = sum_q;
          op2_d   = term_data;
          state_d = S_ISSUE;
        end
      end
      // add_done is deliberately ignored here: it may still be high from the previous add
      S_ISSUE: begin
        tmr_d   = '0;
        state_d = S_WAIT_ADD;
      end
      S_WAIT_ADD: begin
        if (add_done) begin
          sum_d   = add_result;
          ovf_d   = ovf_q | add_overflow;
          rem_d   = rem_q - CNT_W'(1);
          state_d = (rem_q == CNT_W'(1)) ? S_FINISH : S_WAIT_TERM;
        end else begin
          tmr_d = tmr_q + TW'(1);
          if (tmr_q == TW'(TIMEOUT - 1)) begin
            tout_d  = 1'b1;
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign term_ready  = (state_q == S_WAIT_TERM);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FINISH);
  assign op1         = op1_q;
  assign op2         = op2_q;
  assign sum         = sum_q;
  assign overflow    = ovf_q;
  assign timeout_err = tout_q;

endmodule

// File: tb/tb_fp_series_accum.sv
// Randomised bench for fp_series_accum with a behavioural addsub stand-in and a
// run-level reference model (running real-valued sum, expected handshake counts).
module tb_fp_series_accum;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst, start, term_valid, add_done, add_overflow;
  logic [4:0]  num_terms;
  logic [31:0] term_data, add_result, op1, op2, sum;
  logic        term_ready, busy, done, overflow, timeout_err;

  fp_series_accum #(.CNT_W(5), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .num_terms(num_terms),
    .term_valid(term_valid), .term_data(term_data), .term_ready(term_ready),
    .op1(op1), .op2(op2), .add_result(add_result), .add_done(add_done),
    .add_overflow(add_overflow), .sum(sum), .busy(busy), .done(done),
    .overflow(overflow), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic real sp2r(input logic [31:0] b);
    real v; int e;
    if (b[30:0] == 31'h0) return 0.0;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2sp(input real x);
    real v; int e; int m; logic s;
    if (x == 0.0) return 32'h0;
    s = (x < 0.0);
    v = s ? -x : x;
    e = 127;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0)  begin v = v * 2.0; e--; end
    m = $rtoi((v - 1.0) * 8388608.0);
    return {s, 8'(e), 23'(m)};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2sp(sp2r(a) + sp2r(b));
  endfunction

  // addsub stand-in and run bookkeeping
  logic [31:0] terms[$];
  logic [31:0] ref_sum, cur_a, cur_b;
  logic        ref_ovf, cur_ovf;
  bit          pend;
  int          dly, last_dly, lat_cfg, ovf_at, hang_at;
  int          acc_idx, cyc_no = 0, acc_cyc, done_cyc, dcount, tr_hi;

  task automatic cyc();
    bit acc;
    acc = term_valid && term_ready;
    @(posedge clk); #1;
    cyc_no++;
    add_done = 1'b0;
    add_overflow = 1'b0;
    if (pend) begin
      if (dly == 0) begin
        add_done     = 1'b1;
        add_result   = fadd(cur_a, cur_b);
        add_overflow = cur_ovf;
        ref_sum      = add_result;
        ref_ovf      = ref_ovf | cur_ovf;
        pend         = 1'b0;
      end else dly--;
    end
    if (acc) begin
      chk("op1 at accept", op1, ref_sum);
      if (acc_idx < terms.size()) begin
        chk("op2 at accept", op2, terms[acc_idx]);
        cur_a   = ref_sum;
        cur_b   = terms[acc_idx];
        cur_ovf = (acc_idx == ovf_at);
        if (acc_idx != hang_at) begin
          pend     = 1'b1;
          dly      = $urandom_range(0, lat_cfg);
          last_dly = dly;
        end
      end
      acc_idx++;
      acc_cyc = cyc_no;
    end
    if (done) begin dcount++; done_cyc = cyc_no; end
    if (term_ready) tr_hi++;
  endtask

  task automatic run(input string nm, input int n, input bit fixed, input int maxlat,
                     input int ovf_i, input int hang_i, input bit noise, input int gap0);
    logic [31:0] o1, o2, exp_sum;
    bit exp_to;
    int start_cyc;
    if (!fixed) begin
      terms.delete();
      for (int i = 0; i < n; i++) terms.push_back(r2sp($urandom_range(1, 64) / 4.0));
    end
    acc_idx = 0; dcount = 0; tr_hi = 0; ref_sum = 32'h0; ref_ovf = 1'b0; pend = 1'b0;
    lat_cfg = maxlat; ovf_at = ovf_i; hang_at = hang_i;
    num_terms = 5'(n);
    start = 1'b1;
    cyc();
    start = 1'b0;
    start_cyc = cyc_no;
    chk({nm, " busy after start"}, busy, 1'b1);
    chk({nm, " sum cleared"}, sum, 32'h0);
    chk({nm, " overflow cleared"}, overflow, 1'b0);
    chk({nm, " timeout cleared"}, timeout_err, 1'b0);
    o1 = op1; o2 = op2;
    for (int c = 0; c < 3000 && dcount == 0; c++) begin
      term_valid = term_ready && (acc_idx < n) && (c >= gap0) && ($urandom_range(0, 2) != 0);
      if (acc_idx < n) term_data = terms[acc_idx];
      start     = noise && ($urandom_range(0, 3) == 0);
      num_terms = 5'd7;
      cyc();
      if (c < gap0) begin
        chk({nm, " idle ready"}, term_ready, 1'b1);
        chk({nm, " idle op1"}, op1, o1);
        chk({nm, " idle op2"}, op2, o2);
      end
    end
    term_valid = 1'b0;
    start = 1'b0;
    exp_to  = (hang_i >= 0) && (hang_i < n);
    exp_sum = ref_sum;
    chk({nm, " done pulses"}, dcount, 1);
    chk({nm, " sum"}, sum, exp_sum);
    chk({nm, " overflow"}, overflow, ref_ovf);
    chk({nm, " timeout_err"}, timeout_err, exp_to);
    chk({nm, " terms taken"}, acc_idx, exp_to ? hang_i + 1 : n);
    if (n > 0)
      chk({nm, " finish latency"}, done_cyc - acc_cyc, exp_to ? TIMEOUT + 1 : 2 + last_dly);
    else begin
      chk({nm, " zero-term done"}, done_cyc, start_cyc);
      chk({nm, " zero-term ready"}, tr_hi, 0);
    end
    cyc();
    chk({nm, " done cleared"}, done, 1'b0);
    chk({nm, " idle busy"}, busy, 1'b0);
    chk({nm, " sum holds"}, sum, exp_sum);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_terms = 5'd0; term_valid = 1'b0; term_data = 32'h0;
    add_result = 32'h0; add_done = 1'b0; add_overflow = 1'b0;
    pend = 1'b0; hang_at = -1; ovf_at = -1; lat_cfg = 0;
    #12;
    chk("reset sum", sum, 32'h0);
    chk("reset op1", op1, 32'h0);
    chk("reset op2", op2, 32'h0);
    chk("reset busy", busy, 1'b0);
    chk("reset ready", term_ready, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset flags", {overflow, timeout_err}, 2'b00);
    @(negedge clk); rst = 1'b0;
    cyc();

    // Sum of 1.0 + 2.0 + 0.5
    terms.delete();
    terms.push_back(32'h3F800000); terms.push_back(32'h40000000); terms.push_back(32'h3F000000);
    run("series3", 3, 1'b1, 0, -1, -1, 1'b0, 0);
    chk("series3 exact", sum, 32'h40600000);

    run("zero", 0, 1'b0, 0, -1, -1, 1'b0, 0);

    terms.delete();
    terms.push_back(32'h40000000);
    run("gap", 1, 1'b1, 0, -1, -1, 1'b0, 5);
    chk("gap exact", sum, 32'h40000000);

    run("timeout", 3, 1'b0, 2, -1, 1, 1'b0, 0);
    run("ovf", 3, 1'b0, 3, 1, -1, 1'b1, 0);
    run("after ovf", 2, 1'b0, 1, -1, -1, 1'b0, 0);

    // Asynchronous reset while an add is outstanding
    terms.delete();
    terms.push_back(32'h3F800000); terms.push_back(32'h3F800000);
    acc_idx = 0; dcount = 0; ref_sum = 32'h0; ref_ovf = 1'b0; pend = 1'b0; hang_at = 0;
    num_terms = 5'd2; start = 1'b1; cyc(); start = 1'b0;
    term_data = terms[0]; term_valid = 1'b1; cyc(); term_valid = 1'b0;
    cyc(); cyc(); cyc();
    #2 rst = 1'b1; #1;
    chk("rst mid busy", busy, 1'b0);
    chk("rst mid sum", sum, 32'h0);
    chk("rst mid done", done, 1'b0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    chk("rst mid no done", dcount, 0);
    chk("rst mid idle", busy, 1'b0);
    run("post reset", 4, 1'b0, 2, -1, -1, 1'b0, 0);

    for (int r = 0; r < 8; r++)
      run("rand", $urandom_range(1, 12), 1'b0, $urandom_range(0, 4),
          ($urandom_range(0, 1) != 0) ? $urandom_range(0, 5) : -1, -1,
          1'($urandom_range(0, 1)), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
